// File: rtl/pipeline_mnemonic_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_mnemonic_tracker_pkg
//  Description : RV32I opcode / funct codes, display characters and mnemonic
//                name helpers shared by the mnemonic tracker and its ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_mnemonic_tracker_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_OP       = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_LOAD     = 7'b0000011;
    localparam logic [6:0] c_STORE    = 7'b0100011;
    localparam logic [6:0] c_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_JAL      = 7'b1101111;
    localparam logic [6:0] c_JALR     = 7'b1100111;
    localparam logic [6:0] c_LUI      = 7'b0110111;
    localparam logic [6:0] c_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_SYSTEM   = 7'b1110011;

    // funct7 codes
    localparam logic [6:0] c_F7_BASE  = 7'h00;
    localparam logic [6:0] c_F7_ALT   = 7'h20;

    // ALU funct3 codes
    localparam logic [2:0] c_F3_ADD   = 3'd0;
    localparam logic [2:0] c_F3_SLL   = 3'd1;
    localparam logic [2:0] c_F3_SLT   = 3'd2;
    localparam logic [2:0] c_F3_SLTU  = 3'd3;
    localparam logic [2:0] c_F3_XOR   = 3'd4;
    localparam logic [2:0] c_F3_SR    = 3'd5;
    localparam logic [2:0] c_F3_OR    = 3'd6;
    localparam logic [2:0] c_F3_AND   = 3'd7;

    // Display characters
    localparam logic [7:0] c_BUBBLE_CHAR  = 8'h2D;  // '-'
    localparam logic [7:0] c_ILLEGAL_CHAR = 8'h3F;  // '?'
    localparam logic [7:0] c_SPACE_CHAR   = 8'h20;  // ' '

    // Longest RV32I base mnemonic is six characters (EBREAK)
    localparam int NAME_LEN = 6;
    typedef logic [NAME_LEN*8-1:0] name_t;

    // Character k (0 = leftmost) of a left-justified name
    function automatic logic [7:0] name_char(input name_t n, input int k);
        return n[(NAME_LEN-1-k)*8 +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_mnemonic_tracker_rom.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mnemonic_rom
//  Description : Combinational RV32I decoder producing a left-justified,
//                space-padded ASCII mnemonic of CHARS characters plus an
//                illegal-encoding flag (illegal words render as '?').
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mnemonic_rom
    import pipeline_mnemonic_tracker_pkg::*;
#(
    parameter int CHARS = 5
) (
    input  logic [31:0]        i_instr,
    output logic [CHARS*8-1:0] o_chars,
    output logic               o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_sys_regs_zero;
    name_t      w_name;
    logic       w_legal;

    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct7        = i_instr[31:25];
    assign w_sys_regs_zero = (i_instr[19:15] == 5'd0) && (i_instr[11:7] == 5'd0);

    // Decode opcode/funct fields to a six-character name; anything unmatched stays illegal
    always_comb begin
        w_name  = "      ";
        w_legal = 1'b0;
        case (w_opcode)
            c_LUI:   begin w_name = "LUI   "; w_legal = 1'b1; end
            c_AUIPC: begin w_name = "AUIPC "; w_legal = 1'b1; end
            c_JAL:   begin w_name = "JAL   "; w_legal = 1'b1; end
            c_JALR:  if (w_funct3 == 3'd0) begin w_name = "JALR  "; w_legal = 1'b1; end
            c_BRANCH: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'd0:    w_name = "BEQ   ";
                    3'd1:    w_name = "BNE   ";
                    3'd4:    w_name = "BLT   ";
                    3'd5:    w_name = "BGE   ";
                    3'd6:    w_name = "BLTU  ";
                    3'd7:    w_name = "BGEU  ";
                    default: w_legal = 1'b0;
                endcase
            end
            c_LOAD: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'd0:    w_name = "LB    ";
                    3'd1:    w_name = "LH    ";
                    3'd2:    w_name = "LW    ";
                    3'd4:    w_name = "LBU   ";
                    3'd5:    w_name = "LHU   ";
                    default: w_legal = 1'b0;
                endcase
            end
            c_STORE: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'd0:    w_name = "SB    ";
                    3'd1:    w_name = "SH    ";
                    3'd2:    w_name = "SW    ";
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_IMM: begin
                w_legal = 1'b1;
                case (w_funct3)
                    c_F3_ADD:  w_name = "ADDI  ";
                    c_F3_SLT:  w_name = "SLTI  ";
                    c_F3_SLTU: w_name = "SLTIU ";
                    c_F3_XOR:  w_name = "XORI  ";
                    c_F3_OR:   w_name = "ORI   ";
                    c_F3_AND:  w_name = "ANDI  ";
                    c_F3_SLL: begin
                        w_name  = "SLLI  ";
                        w_legal = (w_funct7 == c_F7_BASE);
                    end
                    default: begin  // c_F3_SR
                        w_name  = (w_funct7 == c_F7_ALT) ? "SRAI  " : "SRLI  ";
                        w_legal = (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT);
                    end
                endcase
            end
            c_OP: begin
                if (w_funct7 == c_F7_BASE) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        c_F3_ADD:  w_name = "ADD   ";
                        c_F3_SLL:  w_name = "SLL   ";
                        c_F3_SLT:  w_name = "SLT   ";
                        c_F3_SLTU: w_name = "SLTU  ";
                        c_F3_XOR:  w_name = "XOR   ";
                        c_F3_SR:   w_name = "SRL   ";
                        c_F3_OR:   w_name = "OR    ";
                        default:   w_name = "AND   ";
                    endcase
                end else if (w_funct7 == c_F7_ALT) begin
                    if (w_funct3 == c_F3_ADD) begin
                        w_name  = "SUB   ";
                        w_legal = 1'b1;
                    end else if (w_funct3 == c_F3_SR) begin
                        w_name  = "SRA   ";
                        w_legal = 1'b1;
                    end
                end
            end
            c_MISC_MEM: if (w_funct3 == 3'd0) begin w_name = "FENCE "; w_legal = 1'b1; end
            c_SYSTEM: begin
                if ((w_funct3 == 3'd0) && w_sys_regs_zero) begin
                    if (i_instr[31:20] == 12'd0) begin
                        w_name  = "ECALL ";
                        w_legal = 1'b1;
                    end else if (i_instr[31:20] == 12'd1) begin
                        w_name  = "EBREAK";
                        w_legal = 1'b1;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
        // Compressed-quadrant words are never base ISA
        if (i_instr[1:0] != 2'b11) begin
            w_legal = 1'b0;
        end
    end

    // Render the name into CHARS display cells: truncate or space-pad, or all '?' when illegal
    always_comb begin
        o_chars = '0;
        for (int k = 0; k < CHARS; k++) begin
            if (!w_legal) begin
                o_chars[(CHARS-1-k)*8 +: 8] = c_ILLEGAL_CHAR;
            end else if (k < NAME_LEN) begin
                o_chars[(CHARS-1-k)*8 +: 8] = name_char(w_name, k);
            end else begin
                o_chars[(CHARS-1-k)*8 +: 8] = c_SPACE_CHAR;
            end
        end
    end

    assign o_illegal = ~w_legal;

endmodule
`default_nettype wire

// File: rtl/pipeline_mnemonic_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_mnemonic_tracker
//  Description : Carries the ASCII mnemonic of each fetched RV32I word through
//                NUM_STAGES pipeline stages under stall/flush, and keeps
//                saturating retired and illegal-capture counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_mnemonic_tracker
    import pipeline_mnemonic_tracker_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int CHARS       = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   instr_in,
    input  logic                          instr_valid,
    input  logic                          stall,
    input  logic                          flush,
    output logic [NUM_STAGES*CHARS*8-1:0] stage_chars,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic [NUM_STAGES-1:0]         stage_illegal,
    output logic [CNT_W-1:0]              retired_count,
    output logic [CNT_W-1:0]              illegal_count
);

    localparam int              SW         = CHARS * 8;
    localparam logic [SW-1:0]   c_BUBBLE   = {CHARS{c_BUBBLE_CHAR}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SW-1:0]         chars_q [NUM_STAGES];
    logic [SW-1:0]         chars_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_q,   valid_d;
    logic [NUM_STAGES-1:0] illegal_q, illegal_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic [CNT_W-1:0]      ill_cnt_q, ill_cnt_d;

    logic [SW-1:0] w_rom_chars;
    logic          w_rom_illegal;
    logic          w_advance;
    logic          w_capture;

    rv32i_mnemonic_rom #(
        .CHARS (CHARS)
    ) u_rom (
        .i_instr   (instr_in),
        .o_chars   (w_rom_chars),
        .o_illegal (w_rom_illegal)
    );

    // Flush moves the pipe even when stalled; a flushed-cycle word is never captured
    assign w_advance = flush | ~stall;
    assign w_capture = w_advance & instr_valid & ~flush;

    // Next stage contents: hold, or shift with a fresh stage 0, then bubble the flushed stages
    always_comb begin
        chars_d   = chars_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (w_advance) begin
            chars_d[0]   = w_capture ? w_rom_chars : c_BUBBLE;
            valid_d[0]   = w_capture;
            illegal_d[0] = w_capture & w_rom_illegal;
            for (int i = 1; i < NUM_STAGES; i++) begin
                chars_d[i]   = chars_q[i-1];
                valid_d[i]   = valid_q[i-1];
                illegal_d[i] = illegal_q[i-1];
            end
            if (flush) begin
                for (int i = 0; i < FLUSH_DEPTH; i++) begin
                    chars_d[i]   = c_BUBBLE;
                    valid_d[i]   = 1'b0;
                    illegal_d[i] = 1'b0;
                end
            end
        end
    end

    // Saturating counters: retire on any advance out of a valid last stage
    always_comb begin
        retired_d = retired_q;
        ill_cnt_d = ill_cnt_q;
        if (w_advance && valid_q[NUM_STAGES-1] && (retired_q != '1)) begin
            retired_d = retired_q + c_CNT_ONE;
        end
        if (w_capture && w_rom_illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + c_CNT_ONE;
        end
    end

    // State registers with immediate reset to bubbles and zero counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                chars_q[i] <= c_BUBBLE;
            end
            valid_q   <= '0;
            illegal_q <= '0;
            retired_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                chars_q[i] <= chars_d[i];
            end
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage_out
        assign stage_chars[(g+1)*SW-1 -: SW] = chars_q[g];
    end

    assign stage_valid   = valid_q;
    assign stage_illegal = illegal_q;
    assign retired_count = retired_q;
    assign illegal_count = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mnemonic_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_mnemonic_tracker
//  Description : Self-checking bench for pipeline_mnemonic_tracker (CNT_W=4
//                so counter saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_mnemonic_tracker;

    localparam int N  = 5;
    localparam int C  = 5;
    localparam int W  = C * 8;
    localparam int CW = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    instr_in = '0;
    logic           instr_valid = 1'b0;
    logic           stall = 1'b0;
    logic           flush = 1'b0;
    logic [N*W-1:0] stage_chars;
    logic [N-1:0]   stage_valid;
    logic [N-1:0]   stage_illegal;
    logic [CW-1:0]  retired_count;
    logic [CW-1:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] chars;
        logic         ill;
    } exp_t;
    exp_t exp_q[$];

    pipeline_mnemonic_tracker #(
        .NUM_STAGES  (N),
        .CHARS       (C),
        .FLUSH_DEPTH (2),
        .CNT_W       (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_in      (instr_in),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .flush         (flush),
        .stage_chars   (stage_chars),
        .stage_valid   (stage_valid),
        .stage_illegal (stage_illegal),
        .retired_count (retired_count),
        .illegal_count (illegal_count)
    );

    always #5 clock = ~clock;

    // Left-justified, space-padded, truncated to C characters
    function automatic logic [W-1:0] mk(input string s);
        logic [W-1:0] r;
        for (int k = 0; k < C; k++) begin
            r[(C-1-k)*8 +: 8] = (k < s.len()) ? s[k] : 8'h20;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] stage(input int i);
        return stage_chars[i*W +: W];
    endfunction

    // One clock: drive inputs, queue expected capture, check stage 0 after the edge
    task automatic tick(input logic [31:0] w, input logic v, input logic s, input logic f,
                        input string nm, input logic ill);
        exp_t e;
        logic cap;
        instr_in    = w;
        instr_valid = v;
        stall       = s;
        flush       = f;
        cap = v && !s && !f;
        if (cap) begin
            e.chars = ill ? mk("?????") : mk(nm);
            e.ill   = ill;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (cap) begin
            e = exp_q.pop_front();
            checks++;
            if (stage(0) !== e.chars || stage_illegal[0] !== e.ill || stage_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL capture: got '%s' ill=%b v=%b, want '%s' ill=%b v=1",
                         stage(0), stage_illegal[0], stage_valid[0], e.chars, e.ill);
            end
        end else if (!s || f) begin
            checks++;
            if (stage(0) !== mk("-----") || stage_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL stage0_bubble: got '%s' v=%b, want '-----' v=0",
                         stage(0), stage_valid[0]);
            end
        end
        instr_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (stage_chars !== {N{mk("-----")}} || stage_valid !== '0 || stage_illegal !== '0 ||
            retired_count !== '0 || illegal_count !== '0) begin
            errors++;
            $display("FAIL %s: chars='%s' v=%b ill=%b ret=%0d illc=%0d, want bubbles/0",
                     tag, stage_chars, stage_valid, stage_illegal, retired_count, illegal_count);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_state("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_fill();
        tick(32'h003100B3, 1, 0, 0, "ADD", 0);
        tick(32'h403100B3, 1, 0, 0, "SUB", 0);
        tick(32'h0000A083, 1, 0, 0, "LW", 0);
        tick(32'h00000063, 1, 0, 0, "BEQ", 0);
        tick(32'h123450B7, 1, 0, 0, "LUI", 0);
        checks++;
        if (stage(4) !== mk("ADD") || stage(3) !== mk("SUB") || stage(2) !== mk("LW") ||
            stage(1) !== mk("BEQ") || stage(0) !== mk("LUI")) begin
            errors++;
            $display("FAIL fill_chars: got '%s', want 'ADD  SUB  LW   BEQ  LUI  '", stage_chars);
        end
        checks++;
        if (stage_valid !== 5'b11111 || retired_count !== 4'd0) begin
            errors++;
            $display("FAIL fill_valid: got v=%b ret=%0d, want 11111 0", stage_valid, retired_count);
        end
    endtask

    task automatic test_drain();
        tick(32'h0, 0, 0, 0, "", 0);
        checks++;
        if (retired_count !== 4'd1) begin
            errors++;
            $display("FAIL drain_first_retire: got %0d want 1", retired_count);
        end
        for (int i = 0; i < 4; i++) tick(32'h0, 0, 0, 0, "", 0);
        checks++;
        if (retired_count !== 4'd5 || stage_valid !== '0 || stage_chars !== {N{mk("-----")}}) begin
            errors++;
            $display("FAIL drain_done: got ret=%0d v=%b chars='%s' want 5 00000 bubbles",
                     retired_count, stage_valid, stage_chars);
        end
    endtask

    task automatic test_stall();
        tick(32'h00100093, 1, 0, 0, "ADDI", 0);
        tick(32'h00104093, 1, 0, 0, "XORI", 0);
        for (int i = 0; i < 3; i++) begin
            tick(32'h00112023, 1, 1, 0, "SW", 0);
            checks++;
            if (stage(0) !== mk("XORI") || stage(1) !== mk("ADDI") || stage(2) !== mk("-----") ||
                stage_valid !== 5'b00011 || retired_count !== 4'd5 || illegal_count !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold: got '%s' v=%b ret=%0d illc=%0d, want XORI/ADDI 00011 5 0",
                         stage_chars, stage_valid, retired_count, illegal_count);
            end
        end
    endtask

    task automatic test_flush();
        tick(32'h00107093, 1, 0, 0, "ANDI", 0);
        tick(32'h00000000, 1, 1, 1, "", 0);
        checks++;
        if (stage(1) !== mk("-----") || stage(2) !== mk("XORI") || stage(3) !== mk("ADDI") ||
            stage_valid !== 5'b01100 || illegal_count !== 4'd0 || retired_count !== 4'd5) begin
            errors++;
            $display("FAIL flush: got '%s' v=%b illc=%0d ret=%0d, want -,-,XORI,ADDI 01100 0 5",
                     stage_chars, stage_valid, illegal_count, retired_count);
        end
        for (int i = 0; i < 5; i++) tick(32'h0, 0, 0, 0, "", 0);
        checks++;
        if (retired_count !== 4'd7 || stage_valid !== '0) begin
            errors++;
            $display("FAIL flush_drain: got ret=%0d v=%b want 7 00000", retired_count, stage_valid);
        end
    endtask

    task automatic test_illegal();
        tick(32'h00000000, 1, 0, 0, "", 1);
        tick(32'h023100B3, 1, 0, 0, "", 1);
        tick(32'hFFFFFFFF, 1, 0, 0, "", 1);
        tick(32'h00100073, 1, 0, 0, "EBREAK", 0);
        tick(32'h00000073, 1, 0, 0, "ECALL", 0);
        checks++;
        if (illegal_count !== 4'd3 || stage_illegal !== 5'b11100 || stage(1) !== mk("EBREA")) begin
            errors++;
            $display("FAIL illegal: got illc=%0d ill=%b s1='%s', want 3 11100 'EBREA'",
                     illegal_count, stage_illegal, stage(1));
        end
        for (int i = 0; i < 5; i++) tick(32'h0, 0, 0, 0, "", 0);
        checks++;
        if (retired_count !== 4'd12) begin
            errors++;
            $display("FAIL illegal_retire: got %0d want 12", retired_count);
        end
    endtask

    task automatic test_saturate();
        int exp_ret;
        exp_ret = 12;
        for (int t = 1; t <= 25; t++) begin
            if (t <= 20) tick(32'h003100B3, 1, 0, 0, "ADD", 0);
            else         tick(32'h0, 0, 0, 0, "", 0);
            if (t > 5 && exp_ret < 15) exp_ret++;
            checks++;
            if (retired_count !== exp_ret[CW-1:0]) begin
                errors++;
                $display("FAIL saturate t=%0d: got %0d want %0d", t, retired_count, exp_ret);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(32'h003100B3, 1, 0, 0, "ADD", 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        #1;
        reset = 1'b0;
        tick(32'h123450B7, 1, 0, 0, "LUI", 0);
        checks++;
        if (stage_valid !== 5'b00001 || retired_count !== 4'd0) begin
            errors++;
            $display("FAIL post_reset: got v=%b ret=%0d want 00001 0", stage_valid, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stall();
        test_flush();
        test_illegal();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
